// File: rtl/nested_struct_pkg.sv
// rtl/nested_struct_pkg.sv - shared field width, record types and mask bit positions
//
// Purpose : types shared by the merge helper, the FIFO and its bench.
// Contents: FIELD_W, InnerStruct {a,b,c}, OuterStruct {x,y,z} (9*FIELD_W bits),
//           MASK_X/MASK_Y/MASK_Z bit positions within the 3-bit substruct mask.
package nested_struct_pkg;

    localparam int FIELD_W = 8;

    typedef struct packed {
        logic [FIELD_W-1:0] a;
        logic [FIELD_W-1:0] b;
        logic [FIELD_W-1:0] c;
    } InnerStruct;

    typedef struct packed {
        InnerStruct x;
        InnerStruct y;
        InnerStruct z;
    } OuterStruct;

    localparam int MASK_X = 0;
    localparam int MASK_Y = 1;
    localparam int MASK_Z = 2;

endpackage

// File: rtl/struct_merge.sv
// rtl/struct_merge.sv - per-substruct merge of an offered record with the shadow record
//
// Purpose : purely combinational; each substruct of the result comes from the
//           offered record when its mask bit is set, otherwise from the shadow.
// Ports   : in_data  (OuterStruct) offered record
//           in_mask  (3 bits)      substruct select, bit0=x bit1=y bit2=z
//           shadow   (OuterStruct) last merged record pushed
//           merged   (OuterStruct) resulting record
module struct_merge
    import nested_struct_pkg::*;
(
    input  OuterStruct  in_data,
    input  logic [2:0]  in_mask,
    input  OuterStruct  shadow,
    output OuterStruct  merged
);

    assign merged.x = in_mask[MASK_X] ? in_data.x : shadow.x;
    assign merged.y = in_mask[MASK_Y] ? in_data.y : shadow.y;
    assign merged.z = in_mask[MASK_Z] ? in_data.z : shadow.z;

endmodule

// File: rtl/nested_struct_fifo.sv
// rtl/nested_struct_fifo.sv - record FIFO that stores merged nested-struct records
//
// Purpose : DEPTH-entry FIFO (2..16, any value) of OuterStruct records. Each push
//           stores the merge of the offered record with the shadow (previous
//           pushed record) and updates the shadow on the same edge.
// Ports   : clock, reset (synchronous, active high)
//           in_valid/in_ready/in_data/in_mask  producer side
//           out_valid/out_ready/out_data       consumer side (out_data zero when empty)
//           count                              stored entries
//           shadow                             last merged record pushed
module nested_struct_fifo
    import nested_struct_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  OuterStruct                    in_data,
    input  logic [2:0]                    in_mask,
    output logic                          out_valid,
    input  logic                          out_ready,
    output OuterStruct                    out_data,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output OuterStruct                    shadow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    OuterStruct         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    OuterStruct         r_shadow;

    OuterStruct         w_merged;
    logic               w_push;
    logic               w_pop;
    logic [PTR_W-1:0]   w_head_next;
    logic [PTR_W-1:0]   w_tail_next;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    struct_merge u_merge (
        .in_data (in_data),
        .in_mask (in_mask),
        .shadow  (r_shadow),
        .merged  (w_merged)
    );

    // in_ready looks only at registered count: a pop in the same cycle does
    // not open a slot for a push into a full FIFO.
    assign in_ready    = (r_count != CNT_W'(DEPTH));
    assign out_valid   = (r_count != '0);
    assign w_push      = in_valid && in_ready;
    assign w_pop       = out_valid && out_ready;
    assign w_head_next = ptr_inc(r_head);
    assign w_tail_next = ptr_inc(r_tail);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_shadow <= '0;
        end else begin
            if (w_push) begin
                r_tail   <= w_tail_next;
                r_shadow <= w_merged;
            end
            if (w_pop) begin
                r_head <= w_head_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; the write is still gated so a
    // push offered during reset cannot land in the array.
    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_mem[r_tail] <= w_merged;
        end
    end

    assign out_data = out_valid ? r_mem[r_head] : '0;
    assign count    = r_count;
    assign shadow   = r_shadow;

endmodule

// File: tb/tb_nested_struct_fifo.sv
// tb/tb_nested_struct_fifo.sv - self-checking bench for nested_struct_fifo
module tb_nested_struct_fifo;
    import nested_struct_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // DEPTH=4 instance
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [2:0] a_in_mask;
    logic [2:0] a_count;
    OuterStruct a_in_data, a_out_data, a_shadow;

    // DEPTH=3 instance
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [2:0] b_in_mask;
    logic [1:0] b_count;
    OuterStruct b_in_data, b_out_data, b_shadow;

    nested_struct_fifo #(.DEPTH(4)) u_dut_a (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mask(a_in_mask),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count), .shadow(a_shadow)
    );

    nested_struct_fifo #(.DEPTH(3)) u_dut_b (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mask(b_in_mask),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count), .shadow(b_shadow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of records plus the shadow record per instance.
    OuterStruct qa[$];
    OuterStruct qb[$];
    OuterStruct sa, sb;

    function automatic OuterStruct merge_ref(input OuterStruct d, input logic [2:0] m, input OuterStruct s);
        OuterStruct r;
        r.x = m[0] ? d.x : s.x;
        r.y = m[1] ? d.y : s.y;
        r.z = m[2] ? d.z : s.z;
        return r;
    endfunction

    function automatic OuterStruct rand_rec();
        bit [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    function automatic OuterStruct head_a();
        return (qa.size() != 0) ? qa[0] : OuterStruct'(0);
    endfunction

    function automatic OuterStruct head_b();
        return (qb.size() != 0) ? qb[0] : OuterStruct'(0);
    endfunction

    task automatic idle_all();
        a_in_valid = 0; a_in_mask = 0; a_in_data = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_mask = 0; b_in_data = '0; b_out_ready = 0;
    endtask

    task automatic do_reset();
        idle_all();
        // offer a push and a pop during reset: reset must win
        a_in_valid = 1; a_in_mask = 3'b111; a_in_data = rand_rec(); a_out_ready = 1;
        reset = 1;
        @(posedge clock);
        qa.delete(); qb.delete(); sa = '0; sb = '0;
        @(negedge clock);
        reset = 0;
        idle_all();
    endtask

    task automatic step_a(input logic v, input logic [2:0] m, input OuterStruct d, input logic rdy);
        bit push, pop;
        OuterStruct mrg;
        a_in_valid = v; a_in_mask = m; a_in_data = d; a_out_ready = rdy;
        push = v && (qa.size() != 4);
        pop  = rdy && (qa.size() != 0);
        @(posedge clock);
        if (pop) void'(qa.pop_front());
        if (push) begin
            mrg = merge_ref(d, m, sa);
            qa.push_back(mrg);
            sa = mrg;
        end
        @(negedge clock);
    endtask

    task automatic step_b(input logic v, input logic [2:0] m, input OuterStruct d, input logic rdy);
        bit push, pop;
        OuterStruct mrg;
        b_in_valid = v; b_in_mask = m; b_in_data = d; b_out_ready = rdy;
        push = v && (qb.size() != 3);
        pop  = rdy && (qb.size() != 0);
        @(posedge clock);
        if (pop) void'(qb.pop_front());
        if (push) begin
            mrg = merge_ref(d, m, sb);
            qb.push_back(mrg);
            sb = mrg;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
        checks++; if (a_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", a_count); end
        checks++; if (a_out_data !== OuterStruct'(0)) begin errors++; $display("FAIL reset_out_data: got %h expected 0", a_out_data); end
        checks++; if (a_shadow !== OuterStruct'(0)) begin errors++; $display("FAIL reset_shadow: got %h expected 0", a_shadow); end
        checks++; if (b_out_valid !== 1'b0 || b_count !== 2'd0) begin errors++; $display("FAIL reset_b: got valid %b count %0d expected 0 0", b_out_valid, b_count); end
    endtask

    task automatic test_merge();
        OuterStruct d, e1, e2;
        do_reset();
        d = rand_rec(); d.x = {8'd1, 8'd2, 8'd3};
        step_a(1, 3'b001, d, 0);
        d = rand_rec(); d.y = {8'd4, 8'd5, 8'd6};
        step_a(1, 3'b010, d, 0);
        e1 = {8'd1, 8'd2, 8'd3, 48'd0};
        e2 = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 24'd0};
        checks++; if (a_out_data !== e1) begin errors++; $display("FAIL merge_first: got %h expected %h", a_out_data, e1); end
        checks++; if (a_shadow !== e2) begin errors++; $display("FAIL merge_shadow: got %h expected %h", a_shadow, e2); end
        step_a(0, 3'b000, rand_rec(), 1);
        checks++; if (a_out_data !== e2) begin errors++; $display("FAIL merge_second: got %h expected %h", a_out_data, e2); end
        step_a(0, 3'b000, rand_rec(), 1);
        checks++; if (a_out_valid !== 1'b0 || a_count !== 3'd0) begin errors++; $display("FAIL merge_drain: got valid %b count %0d expected 0 0", a_out_valid, a_count); end
        // pops must not disturb the shadow
        checks++; if (a_shadow !== e2) begin errors++; $display("FAIL merge_shadow_after_pop: got %h expected %h", a_shadow, e2); end
    endtask

    task automatic test_full();
        OuterStruct r[5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            r[i] = rand_rec();
            step_a(1, 3'b111, r[i], 0);
        end
        checks++; if (a_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", a_count); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", a_in_ready); end
        checks++; if (a_shadow !== r[3]) begin errors++; $display("FAIL full_shadow: got %h expected %h", a_shadow, r[3]); end
        checks++; if (a_out_data !== r[0]) begin errors++; $display("FAIL full_head: got %h expected %h", a_out_data, r[0]); end
        // push offered together with a pop while full: only the pop happens
        step_a(1, 3'b111, rand_rec(), 1);
        checks++; if (a_count !== 3'd3) begin errors++; $display("FAIL full_push_pop: got %0d expected 3", a_count); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (a_out_data !== r[i]) begin errors++; $display("FAIL full_order[%0d]: got %h expected %h", i, a_out_data, r[i]); end
            step_a(0, 3'b000, rand_rec(), 1);
        end
        checks++; if (a_count !== 3'd0) begin errors++; $display("FAIL full_end_count: got %0d expected 0", a_count); end
    endtask

    task automatic test_back_to_back();
        OuterStruct r1, r2;
        do_reset();
        r1 = rand_rec(); r2 = rand_rec();
        step_a(1, 3'b111, r1, 0);
        step_a(1, 3'b111, r2, 0);
        checks++; if (a_count !== 3'd2) begin errors++; $display("FAIL b2b_pre_count: got %0d expected 2", a_count); end
        step_a(1, 3'b111, rand_rec(), 1);
        checks++; if (a_count !== 3'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", a_count); end
        checks++; if (a_out_data !== r2) begin errors++; $display("FAIL b2b_head: got %h expected %h", a_out_data, r2); end
    endtask

    task automatic test_wrap();
        int n;
        int got[$];
        OuterStruct d;
        do_reset();
        n = 1;
        for (int cyc = 0; cyc < 60 && got.size() < 10; cyc++) begin
            checks++; if (b_in_ready !== (qb.size() != 3)) begin errors++; $display("FAIL wrap_in_ready: got %b expected %b", b_in_ready, qb.size() != 3); end
            if (b_out_valid) got.push_back(int'(b_out_data.z.a));
            d = rand_rec(); d.z.a = 8'(n);
            if (n <= 10 && qb.size() != 3) begin
                step_b(1, 3'b111, d, 1);
                n++;
            end else begin
                step_b(n <= 10, 3'b111, d, 1);
            end
        end
        checks++; if (got.size() != 10) begin errors++; $display("FAIL wrap_pops: got %0d expected 10", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] != i + 1) begin errors++; $display("FAIL wrap_order[%0d]: got %0d expected %0d", i, got[i], i + 1); end
        end
        checks++; if (b_count !== 2'd0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", b_count); end
        idle_all();
    endtask

    task automatic test_reset_mid();
        OuterStruct d;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = rand_rec(); d.x.a = 8'hA5;
            step_a(1, 3'b111, d, 0);
        end
        checks++; if (a_count !== 3'd3) begin errors++; $display("FAIL rmid_pre_count: got %0d expected 3", a_count); end
        do_reset();
        checks++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_state: got count %0d valid %b expected 0 0", a_count, a_out_valid); end
        checks++; if (a_shadow !== OuterStruct'(0)) begin errors++; $display("FAIL rmid_shadow: got %h expected 0", a_shadow); end
        step_a(1, 3'b000, rand_rec(), 0);
        checks++; if (a_out_valid !== 1'b1 || a_count !== 3'd1) begin errors++; $display("FAIL rmid_push: got valid %b count %0d expected 1 1", a_out_valid, a_count); end
        checks++; if (a_out_data !== OuterStruct'(0)) begin errors++; $display("FAIL rmid_zero_rec: got %h expected 0", a_out_data); end
    endtask

    task automatic test_empty();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step_a(0, 3'($urandom()), rand_rec(), 1);
            checks++;
            if (a_out_valid !== 1'b0 || a_out_data !== OuterStruct'(0) || a_count !== 3'd0 || a_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL empty[%0d]: got valid %b data %h count %0d ready %b expected 0 0 0 1", i, a_out_valid, a_out_data, a_count, a_in_ready);
            end
        end
    endtask

    task automatic test_random();
        OuterStruct exp;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            exp = head_a();
            checks++;
            if (a_count !== 3'(qa.size()) || a_out_valid !== (qa.size() != 0) || a_in_ready !== (qa.size() != 4)
                || a_out_data !== exp || a_shadow !== sa) begin
                errors++;
                $display("FAIL rand_a[%0d]: got count %0d data %h shadow %h expected count %0d data %h shadow %h",
                         i, a_count, a_out_data, a_shadow, qa.size(), exp, sa);
            end
            // alternate fill-biased and drain-biased phases
            step_a(($urandom() % 4) != 0, 3'($urandom()), rand_rec(),
                   ((i / 40) % 2 == 0) ? (($urandom() % 4) == 0) : (($urandom() % 4) != 0));
        end
        idle_all();
        for (int i = 0; i < 150; i++) begin
            exp = head_b();
            checks++;
            if (b_count !== 2'(qb.size()) || b_out_valid !== (qb.size() != 0) || b_in_ready !== (qb.size() != 3)
                || b_out_data !== exp || b_shadow !== sb) begin
                errors++;
                $display("FAIL rand_b[%0d]: got count %0d data %h shadow %h expected count %0d data %h shadow %h",
                         i, b_count, b_out_data, b_shadow, qb.size(), exp, sb);
            end
            step_b(($urandom() % 3) != 0, 3'($urandom()), rand_rec(), ($urandom() % 2) != 0);
        end
        idle_all();
    endtask

    initial begin
        reset = 1;
        idle_all();
        @(negedge clock);
        test_reset();
        test_merge();
        test_full();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_empty();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
